// File: rtl/branch_predict_btb.sv
// IF-stage branch predictor: fully associative BTB with saturating direction counters,
// tree-PLRU replacement and a circular return-address stack trained from EX.
module branch_predict_btb #(
  parameter int WIDTH        = 4,
  parameter int LINE_NUM     = 2**WIDTH,
  parameter int ADDR_WIDTH   = 32,
  parameter int COUNTER_BITS = 2,
  parameter int RAS_WIDTH    = 2,
  parameter int RAS_DEPTH    = 2**RAS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] request_pc,
  output logic                  request_miss,
  output logic [WIDTH-1:0]      request_index,
  output logic                  request_taken,
  output logic [ADDR_WIDTH-1:0] request_target,
  input  logic                  update_en,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  input  logic [1:0]            update_kind,
  output logic                  ras_valid
);

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_CALL   = 2'b10;
  localparam logic [1:0] KIND_RETURN = 2'b11;

  localparam logic [COUNTER_BITS-1:0] CNT_MAX        = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ZERO       = '0;
  localparam logic [COUNTER_BITS-1:0] CNT_WEAK_TAKEN = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_WEAK_NOT   = CNT_WEAK_TAKEN - COUNTER_BITS'(1);

  logic                    line_valid  [LINE_NUM];
  logic [ADDR_WIDTH-1:0]   line_tag    [LINE_NUM];
  logic [ADDR_WIDTH-1:0]   line_target [LINE_NUM];
  logic [1:0]              line_kind   [LINE_NUM];
  logic [COUNTER_BITS-1:0] line_cnt    [LINE_NUM];

  // Heap-ordered tree: node n has children 2n and 2n+1; a 0 bit steers the victim left.
  logic [LINE_NUM-1:1] plru, plru_next;

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_WIDTH-1:0]  ras_ptr, ras_top_idx;
  logic [RAS_WIDTH:0]    ras_count;

  logic                    req_hit;
  logic [WIDTH-1:0]        req_idx;
  logic                    upd_hit, free_any, do_alloc, do_touch;
  logic [WIDTH-1:0]        upd_idx, free_idx, victim_idx, alloc_idx, touch_idx;
  logic [WIDTH:0]          vnode, tnode;
  logic [COUNTER_BITS-1:0] cnt_cur, cnt_upd;

  assign ras_valid   = (ras_count != '0);
  assign ras_top_idx = ras_ptr - RAS_WIDTH'(1);

  always_comb begin
    req_hit = 1'b0;
    req_idx = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (line_valid[i] && line_tag[i] == request_pc) begin
        req_hit = 1'b1;
        req_idx = WIDTH'(i);
      end
    end
    request_miss   = ~req_hit;
    request_index  = req_idx;
    request_taken  = req_hit && (line_kind[req_idx] != KIND_BRANCH ||
                                 line_cnt[req_idx][COUNTER_BITS-1]);
    request_target = '0;
    if (req_hit) begin
      if (line_kind[req_idx] == KIND_RETURN && ras_valid)
        request_target = ras_mem[ras_top_idx];
      else
        request_target = line_target[req_idx];
    end
  end

  // Update path does its own tag match; the IF-stage index may be stale by now.
  always_comb begin
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (line_valid[i] && line_tag[i] == update_pc) begin
        upd_hit = 1'b1;
        upd_idx = WIDTH'(i);
      end
      if (!line_valid[i]) begin
        free_any = 1'b1;
        free_idx = WIDTH'(i);
      end
    end

    vnode = (WIDTH+1)'(1);
    for (int l = 0; l < WIDTH; l++)
      vnode = {vnode[WIDTH-1:0], plru[vnode[WIDTH-1:0]]};
    victim_idx = vnode[WIDTH-1:0];

    alloc_idx = free_any ? free_idx : victim_idx;
    do_alloc  = update_en && !upd_hit && !(update_kind == KIND_BRANCH && !update_taken);
    do_touch  = (update_en && upd_hit) || do_alloc;
    touch_idx = upd_hit ? upd_idx : alloc_idx;

    plru_next = plru;
    tnode     = (WIDTH+1)'(1);
    if (do_touch) begin
      for (int l = 0; l < WIDTH; l++) begin
        plru_next[tnode[WIDTH-1:0]] = ~touch_idx[WIDTH-1-l];
        tnode = {tnode[WIDTH-1:0], touch_idx[WIDTH-1-l]};
      end
    end

    cnt_cur = line_cnt[upd_idx];
    if (update_taken)
      cnt_upd = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + COUNTER_BITS'(1);
    else
      cnt_upd = (cnt_cur == CNT_ZERO) ? cnt_cur : cnt_cur - COUNTER_BITS'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_NUM; i++) begin
        line_valid[i]  <= 1'b0;
        line_tag[i]    <= '0;
        line_target[i] <= '0;
        line_kind[i]   <= KIND_BRANCH;
        line_cnt[i]    <= '0;
      end
      plru <= '0;
    end else begin
      plru <= plru_next;
      if (update_en && upd_hit) begin
        line_target[upd_idx] <= update_target;
        line_kind[upd_idx]   <= update_kind;
        line_cnt[upd_idx]    <= cnt_upd;
      end else if (do_alloc) begin
        line_valid[alloc_idx]  <= 1'b1;
        line_tag[alloc_idx]    <= update_pc;
        line_target[alloc_idx] <= update_target;
        line_kind[alloc_idx]   <= update_kind;
        line_cnt[alloc_idx]    <= update_taken ? CNT_WEAK_TAKEN : CNT_WEAK_NOT;
      end
    end
  end

  // Calls overwrite the oldest entry once full; popping an empty stack does nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_mem[i] <= '0;
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (update_en) begin
      case (update_kind)
        KIND_CALL: begin
          ras_mem[ras_ptr] <= update_pc + ADDR_WIDTH'(8);
          ras_ptr          <= ras_ptr + RAS_WIDTH'(1);
          if (ras_count != (RAS_WIDTH+1)'(RAS_DEPTH))
            ras_count <= ras_count + (RAS_WIDTH+1)'(1);
        end
        KIND_RETURN: begin
          if (ras_valid) begin
            ras_ptr   <= ras_top_idx;
            ras_count <= ras_count - (RAS_WIDTH+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
